ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: id_ex_valid  input  1  id_ex_bundle holds a valid instruction.
REQ-004 SHALL have ports: id_ex_ready  output  1  stage accepts id_ex_bundle this cycle.
REQ-005 SHALL have ports: id_ex_bundle  input  147  {ctrl[146:138], npc[137:106], rd1[105:74], rd2[73:42], sext[41:10], rt[9:5], rd[4:0]}.
REQ-006 SHALL have ports: ex_mem_valid  output  1  ex_mem_bundle valid.
REQ-007 SHALL have ports: ex_mem_ready  input  1  downstream accepts ex_mem_bundle.
REQ-008 SHALL have ports: ex_mem_bundle  output  107  {wb[106:105], m[104:102], br_target[101:70], zero[69], alu_res[68:37], rd2[36:5], dest[4:0]}.
REQ-009 SHALL have ports: busy  output  1  multiplier in progress.
REQ-010 SHALL decode ctrl as [8]Branch [7]MemRead [6]MemWrite [5]RegWrite [4]MemtoReg [3]RegDst [2:1]ALUOp [0]ALUSrc.

Function
REQ-011 SHALL accept an instruction on a clk edge iff id_ex_valid && id_ex_ready.
REQ-012 SHALL drive id_ex_ready = 1 only in IDLE with output register empty, or in IDLE when the held output is consumed the same cycle (ex_mem_ready=1).
REQ-013 SHALL use operand B = sext when ALUSrc=1, else rd2; operand A = rd1.
REQ-014 SHALL select ALU op: ALUOp 00 add; 01 sub; 11 signed slt; 10 per funct=sext[5:0]: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt, 0x18 mul; any other funct gives alu_res=0.
REQ-015 SHALL compute add/sub modulo 2^32, no overflow flag; slt result 32'd1 or 32'd0.
REQ-016 SHALL set zero = (alu_res == 0).
REQ-017 SHALL set br_target = npc + (sext << 2), modulo 2^32.
REQ-018 SHALL set dest = rd when RegDst=1, else rt; wb = {RegWrite, MemtoReg}; m = {Branch, MemRead, MemWrite}; rd2 field = id_ex_bundle rd2 (unmuxed).
REQ-019 SHALL implement FSM states IDLE, MUL, HOLD.
REQ-020 IDLE: accepted non-mul instruction -> result registered, ex_mem_valid=1 next cycle (latency 1), stay IDLE.
REQ-021 IDLE: accepted mul (ALUOp=10, funct=0x18) -> MUL; latch operands; counter=0; busy=1.
REQ-022 MUL: one shift-add step per cycle over 32 cycles; alu_res = low 32 bits of unsigned A*B; ex_mem_valid asserts 33 cycles after accept.
REQ-023 MUL: id_ex_ready=0 throughout; counter at 31 -> write result, go HOLD if ex_mem_ready=0 at result time, else IDLE.
REQ-024 ex_mem_valid with ex_mem_ready=0 SHALL hold ex_mem_bundle stable; no new accept until consumed.
REQ-025 HOLD: remain until ex_mem_ready=1, then IDLE.
REQ-026 ex_mem_valid SHALL deassert the cycle after consumption unless a new result is loaded that edge.
REQ-027 busy SHALL equal (state == MUL).
REQ-028 Bundle fields outside valid cycles SHALL be don't-care except at reset.

Reset
REQ-029 reset SHALL asynchronously force state=IDLE, counter=0, ex_mem_valid=0, ex_mem_bundle=107'b0, busy=0.
REQ-030 reset asserted during MUL SHALL abort the multiply; no result emitted after release.
REQ-031 id_ex_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-032 add: ctrl=RegDst|RegWrite|ALUOp10, rd1=5, rd2=7, funct=0x20, rd=3 -> next cycle alu_res=12, zero=0, dest=3, wb=2'b10.
REQ-033 beq: Branch, ALUOp01, rd1=rd2=9, npc=0x100, sext=4 -> zero=1, alu_res=0, br_target=0x110, m=3'b100.
REQ-034 lw: MemRead|MemtoReg|RegWrite|ALUSrc, ALUOp00, rd1=0x1000, sext=0xFFFFFFFC, rt=8 -> alu_res=0xFFC, dest=8.
REQ-035 mul: rd1=0x10000, rd2=0x30003 -> busy 32 cycles, id_ex_ready=0, then alu_res=0x00030000 (low word of 0x3_0003_0000).
REQ-036 backpressure: ex_mem_ready=0 for 5 cycles after valid result -> bundle constant, id_ex_ready=0; on ready=1 consumed, next instruction accepted same edge.
REQ-037 reset at cycle 10 of a mul -> outputs zero, ex_mem_valid never asserts for that mul; next add completes with latency 1.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch target, destination select and an
// iterative 32-cycle shift-add multiplier behind a valid/ready output register.
module ex_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         id_ex_valid,
    output logic         id_ex_ready,
    input  logic [146:0] id_ex_bundle,
    output logic         ex_mem_valid,
    input  logic         ex_mem_ready,
    output logic [106:0] ex_mem_bundle,
    output logic         busy
);

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic       alu_src;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] npc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } id_ex_t;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] br_target;
        logic        zero;
        logic [31:0] alu_res;
        logic [31:0] rd2;
        logic [4:0]  dest;
    } ex_mem_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        HOLD
    } state_t;

    state_t      state_q;
    state_t      state_d;
    id_ex_t      in;
    ex_mem_t     new_res;
    ex_mem_t     mul_res;
    ex_mem_t     out_q;
    ex_mem_t     pend_q;
    logic        out_valid_q;
    logic [4:0]  cnt_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] prod_q;
    logic [31:0] prod_next;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [5:0]  funct;
    logic        is_r;
    logic        sel_add;
    logic        sel_sub;
    logic        sel_and;
    logic        sel_or;
    logic        sel_slt;
    logic        sel_mul;
    logic        can_take;
    logic        accept;
    logic        last;

    assign in            = id_ex_bundle;
    assign ex_mem_bundle = out_q;
    assign ex_mem_valid  = out_valid_q;

    assign op_a  = in.rd1;
    assign op_b  = in.ctrl.alu_src ? in.sext : in.rd2;
    assign funct = in.sext[5:0];
    assign is_r  = (in.ctrl.alu_op == 2'b10);

    assign sel_add = (in.ctrl.alu_op == 2'b00) || (is_r && funct == 6'h20);
    assign sel_sub = (in.ctrl.alu_op == 2'b01) || (is_r && funct == 6'h22);
    assign sel_and = is_r && (funct == 6'h24);
    assign sel_or  = is_r && (funct == 6'h25);
    assign sel_slt = (in.ctrl.alu_op == 2'b11) || (is_r && funct == 6'h2A);
    assign sel_mul = is_r && (funct == 6'h18);

    // Input is taken only in IDLE with the output slot free or draining now.
    assign can_take    = (state_q == IDLE) && (!out_valid_q || ex_mem_ready);
    assign id_ex_ready = can_take;
    assign accept      = id_ex_valid && can_take;

    assign last      = (cnt_q == 5'd31);
    assign prod_next = prod_q + (mplier_q[0] ? mcand_q : 32'd0);

    // Single-cycle ALU; mul and unknown functs fall through to zero.
    always_comb begin
        alu_res = '0;
        unique case (1'b1)
            sel_add: alu_res = op_a + op_b;
            sel_sub: alu_res = op_a - op_b;
            sel_and: alu_res = op_a & op_b;
            sel_or:  alu_res = op_a | op_b;
            sel_slt: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            default: alu_res = '0;
        endcase
    end

    // Assemble the outgoing bundle for the instruction on the input.
    always_comb begin
        new_res           = '0;
        new_res.wb        = {in.ctrl.reg_write, in.ctrl.mem_to_reg};
        new_res.m         = {in.ctrl.branch, in.ctrl.mem_read,
                             in.ctrl.mem_write};
        new_res.br_target = in.npc + (in.sext << 2);
        new_res.zero      = (alu_res == 32'd0);
        new_res.alu_res   = alu_res;
        new_res.rd2       = in.rd2;
        new_res.dest      = in.ctrl.reg_dst ? in.rd : in.rt;
    end

    // Merge the finished product into the fields parked at mul accept.
    always_comb begin
        mul_res         = pend_q;
        mul_res.alu_res = prod_next;
        mul_res.zero    = (prod_next == 32'd0);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and busy flag.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && sel_mul) begin
                    state_d = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (last) begin
                    state_d = ex_mem_ready ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (ex_mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register, multiplier datapath and step counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            pend_q      <= '0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
        end else if (state_q == MUL) begin
            prod_q   <= prod_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 5'd1;
            if (last) begin
                out_q       <= mul_res;
                out_valid_q <= 1'b1;
            end
        end else if (accept) begin
            if (sel_mul) begin
                pend_q      <= new_res;
                mcand_q     <= op_a;
                mplier_q    <= op_b;
                prod_q      <= '0;
                cnt_q       <= '0;
                out_valid_q <= 1'b0;
            end else begin
                out_q       <= new_res;
                out_valid_q <= 1'b1;
            end
        end else if (out_valid_q && ex_mem_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule
